// File: rtl/irq_priority_ctrl_pkg.sv
// Shared constants and lowest-set-bit encoder for the interrupt controller.
// Also used by the CPU cause-register logic.
package irq_priority_ctrl_pkg;

    localparam int IRQ_NUM  = 3;
    localparam int IRQ_ID_W = 4;
    localparam int ENC_MAX  = 16;

`ifdef IRQ_SYNC_EN
    localparam bit IRQ_SYNC_DEFAULT = 1'b1;
`else
    localparam bit IRQ_SYNC_DEFAULT = 1'b0;
`endif

    typedef struct packed {
        logic       valid;
        logic [3:0] idx;
    } enc_t;

    function automatic enc_t lowest_set(input logic [ENC_MAX-1:0] vec);
        enc_t r;
        r = '0;
        for (int i = ENC_MAX - 1; i >= 0; i--) begin
            if (vec[i]) begin
                r.valid = 1'b1;
                r.idx   = 4'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/irq_priority_ctrl_enc.sv
// irq_prio_enc: combinational lowest-index encoder, W up to 16 bits.
module irq_prio_enc
    import irq_priority_ctrl_pkg::*;
#(
    parameter int W  = 3,
    parameter int IW = 4
) (
    input  logic [W-1:0]  vec,
    output logic          valid,
    output logic [IW-1:0] idx
);

    enc_t r;

    always_comb begin
        r = lowest_set(ENC_MAX'(vec));
    end

    assign valid = r.valid;
    assign idx   = IW'(r.idx);

endmodule

// File: rtl/irq_priority_ctrl.sv
// Edge-captured, maskable, fixed-priority nesting interrupt controller.
// IRQ_SYNC_EN adds a 2-flop input synchroniser ahead of edge detection.
module irq_priority_ctrl
    import irq_priority_ctrl_pkg::*;
#(
    parameter int NUM_IRQ = IRQ_NUM,
    parameter int ID_W    = IRQ_ID_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               mask_we,
    input  logic [NUM_IRQ-1:0] mask_wdata,
    output logic               irq_req,
    output logic [ID_W-1:0]    irq_id,
    input  logic               irq_ack,
    input  logic               irq_eoi,
    output logic [NUM_IRQ-1:0] pending,
    output logic [NUM_IRQ-1:0] in_service,
    output logic [NUM_IRQ-1:0] mask
);

    logic [NUM_IRQ-1:0] irq_src;
    logic [NUM_IRQ-1:0] irq_prev;
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] eligible;
    logic [NUM_IRQ-1:0] ack_clr;
    logic [NUM_IRQ-1:0] eoi_clr;
    logic               best_v;
    logic               cur_v;
    logic [ID_W-1:0]    best;
    logic [ID_W-1:0]    cur;
    logic               ack_fire;
    logic               req_cond;

`ifdef IRQ_SYNC_EN
    logic [NUM_IRQ-1:0] sync_q1;
    logic [NUM_IRQ-1:0] sync_q2;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= irq_in;
            sync_q2 <= sync_q1;
        end
    end

    assign irq_src = sync_q2;
`else
    assign irq_src = irq_in;
`endif

    assign rise     = irq_src & ~irq_prev;
    assign eligible = pending & mask;

    irq_prio_enc #(.W(NUM_IRQ), .IW(ID_W)) u_enc_best (
        .vec   (eligible),
        .valid (best_v),
        .idx   (best)
    );

    irq_prio_enc #(.W(NUM_IRQ), .IW(ID_W)) u_enc_cur (
        .vec   (in_service),
        .valid (cur_v),
        .idx   (cur)
    );

    // Preempt only when strictly higher priority than the active handler
    assign req_cond = best_v && (!cur_v || best < cur);
    assign ack_fire = irq_ack && irq_req;
    assign ack_clr  = ack_fire ? (NUM_IRQ'(1) << irq_id) : '0;
    assign eoi_clr  = (irq_eoi && cur_v) ? (NUM_IRQ'(1) << cur) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            irq_prev   <= '0;
            pending    <= '0;
            in_service <= '0;
            mask       <= '1;
            irq_req    <= 1'b0;
            irq_id     <= '0;
        end else begin
            irq_prev   <= irq_src;
            pending    <= (pending & ~ack_clr) | rise;
            in_service <= (in_service & ~eoi_clr) | ack_clr;
            if (mask_we) begin
                mask <= mask_wdata;
            end
            irq_req <= req_cond && !ack_fire;
            if (req_cond) begin
                irq_id <= best;
            end
        end
    end

endmodule
